ones_pattern_gen: RTL and testbench

//  Inverse of the popcount path: accepts a ones-count and serialises a FRAME_LEN-bit frame

---
 rtl/ones_pattern_gen_pkg.sv | 11 +
 rtl/ones_pattern_gen_if.sv | 22 ++
 rtl/ones_pattern_gen.sv | 86 ++++++++
 tb/tb_ones_pattern_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_pattern_gen_pkg.sv
// Shared types and sizing helpers for the ones-pattern generator and its popcount receiver.
package ones_pkg;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ones_state_e;

   // Width needed to hold a count in 0..frame_len inclusive.
   function automatic int cnt_w(input int frame_len);
      return $clog2(frame_len + 1);
   endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Count-in / serial-bit-out handshake bundle for ones_pattern_gen.
interface ones_pattern_gen_if #(
   parameter int CNT_W = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [CNT_W-1:0] in_count;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic             out_last;

   modport master (
      output in_valid, in_count, out_ready,
      input  in_ready, out_valid, out_bit, out_last
   );

   modport slave (
      input  in_valid, in_count, out_ready,
      output in_ready, out_valid, out_bit, out_last
   );
endinterface

// File: rtl/ones_pattern_gen.sv
// Turns a ones-count into a FRAME_LEN-bit serial thermometer frame (1s first, then 0s).
module ones_pattern_gen
   import ones_pkg::*;
#(
   parameter int FRAME_LEN = 3,
   parameter int CNT_W     = cnt_w(FRAME_LEN),
   parameter int FCNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   ones_pattern_gen_if.slave bus,
   output logic              ovf,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);

   ones_state_e      state;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] idx_nxt;
   logic [CNT_W-1:0] cnt_clamp;
   logic             too_big;
   logic             accept;
   logic             fire;

   always_comb begin
      too_big   = bus.in_count > LEN_C;
      cnt_clamp = too_big ? LEN_C : bus.in_count;
      accept    = bus.in_valid && bus.in_ready;
      fire      = bus.out_valid && bus.out_ready;
      idx_nxt   = idx + CNT_W'(1);
   end

   // Outputs are registered alongside the state; the bit for the next beat is
   // precomputed from idx_nxt so out_bit/out_last always describe the current idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt_q         <= '0;
         idx           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_bit   <= 1'b0;
         bus.out_last  <= 1'b0;
         ovf           <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         ovf <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state         <= SEND;
                  cnt_q         <= cnt_clamp;
                  idx           <= '0;
                  ovf           <= too_big;
                  bus.in_ready  <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.out_bit   <= cnt_clamp != '0;
                  bus.out_last  <= LAST_C == '0;
               end
            end
            SEND: begin
               if (fire) begin
                  if (bus.out_last) begin
                     state         <= IDLE;
                     idx           <= '0;
                     frame_cnt     <= frame_cnt + FCNT_W'(1);
                     bus.in_ready  <= 1'b1;
                     bus.out_valid <= 1'b0;
                     bus.out_bit   <= 1'b0;
                     bus.out_last  <= 1'b0;
                  end else begin
                     idx          <= idx_nxt;
                     bus.out_bit  <= idx_nxt < cnt_q;
                     bus.out_last <= idx_nxt == LAST_C;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: FRAME_LEN=3 and FRAME_LEN=5 instances against a thermometer model.
module tb_ones_pattern_gen;
   import ones_pkg::*;

   localparam int FLA = 3;
   localparam int FLB = 5;
   localparam int CWA = cnt_w(FLA);
   localparam int CWB = cnt_w(FLB);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ones_pattern_gen_if #(.CNT_W(CWA)) ia ();
   ones_pattern_gen_if #(.CNT_W(CWB)) ib ();

   logic        ovf_a, ovf_b;
   logic [15:0] fc_a, fc_b;

   ones_pattern_gen #(.FRAME_LEN(FLA), .CNT_W(CWA), .FCNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ia), .ovf(ovf_a), .frame_cnt(fc_a));
   ones_pattern_gen #(.FRAME_LEN(FLB), .CNT_W(CWB), .FCNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ib), .ovf(ovf_b), .frame_cnt(fc_b));

   int checks = 0;
   int failures = 0;
   int fcm [2];

   typedef struct {
      int sel;
      int cnt;
      int stall;
      int exp_bits;
      int exp_ovf;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic logic g_rdy(input int s);  return s ? ib.in_ready  : ia.in_ready;  endfunction
   function automatic logic g_vld(input int s);  return s ? ib.out_valid : ia.out_valid; endfunction
   function automatic logic g_bit(input int s);  return s ? ib.out_bit   : ia.out_bit;   endfunction
   function automatic logic g_last(input int s); return s ? ib.out_last  : ia.out_last;  endfunction
   function automatic logic g_ovf(input int s);  return s ? ovf_b : ovf_a;               endfunction
   function automatic logic [15:0] g_fc(input int s); return s ? fc_b : fc_a;            endfunction
   function automatic int flen(input int s);     return s ? FLB : FLA;                   endfunction

   // Model: k = min(count, len) ones, MSB-first, then zeros.
   function automatic int thermo(input int c, input int fl);
      int k;
      k = (c > fl) ? fl : c;
      return ((1 << k) - 1) << (fl - k);
   endfunction

   task automatic set_in(input int s, input logic v, input int c);
      if (s != 0) begin ib.in_valid = v; ib.in_count = CWB'(c); end
      else        begin ia.in_valid = v; ia.in_count = CWA'(c); end
   endtask

   task automatic set_ord(input int s, input logic r);
      if (s != 0) ib.out_ready = r;
      else        ia.out_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a count and hold it until the edge that accepts it; returns just after that edge.
   task automatic accept(input int s, input int c);
      int n;
      n = 0;
      set_in(s, 1'b1, c);
      while (!g_rdy(s) && n < 50) begin tick(); n++; end
      if (!g_rdy(s)) chk("accept_timeout", 64'(n), 64'd0);
      tick();
      set_in(s, 1'b0, 0);
   endtask

   task automatic run_frame(input int s, input int fl, input int stall,
                            output int bits, output int len, output int cyc);
      logic r, pb, pl, done;
      bits = 0; len = 0; cyc = 0; done = 1'b0;
      while (!done) begin
         if (cyc >= 200) begin
            chk("frame_timeout", 64'(cyc), 64'(fl));
            done = 1'b1;
         end else if (!g_vld(s)) begin
            chk("valid_in_frame", 64'(g_vld(s)), 64'd1);
            done = 1'b1;
         end else begin
            r = ($urandom_range(99) >= stall);
            set_ord(s, r);
            chk("in_ready_in_send", 64'(g_rdy(s)), 64'd0);
            pb = g_bit(s);
            pl = g_last(s);
            if (r) begin
               bits = (bits << 1) | int'(pb);
               len++;
               chk("last_pos", 64'(pl), 64'(len == fl));
               if (pl || len >= fl) done = 1'b1;
            end
            tick();
            cyc++;
            if (!r) begin
               chk("hold_bit", 64'(g_bit(s)), 64'(pb));
               chk("hold_last", 64'(g_last(s)), 64'(pl));
            end
         end
      end
      set_ord(s, 1'b0);
   endtask

   task automatic frame_done(input int s);
      fcm[s] = (fcm[s] + 1) & 32'hFFFF;
      chk("frame_cnt", 64'(g_fc(s)), 64'(fcm[s]));
      chk("idle_ready", 64'(g_rdy(s)), 64'd1);
      chk("idle_valid", 64'(g_vld(s)), 64'd0);
   endtask

   initial begin
      int bits, len, cyc, s, c;
      ia.in_valid = 0; ia.in_count = '0; ia.out_ready = 0;
      ib.in_valid = 0; ib.in_count = '0; ib.out_ready = 0;
      fcm[0] = 0; fcm[1] = 0;

      tbl[0] = '{0, 2, 0,  32'b110,   0};
      tbl[1] = '{0, 0, 0,  32'b000,   0};
      tbl[2] = '{0, 3, 0,  32'b111,   0};
      tbl[3] = '{0, 1, 40, 32'b100,   0};
      tbl[4] = '{1, 7, 0,  32'b11111, 1};
      tbl[5] = '{1, 5, 20, 32'b11111, 0};
      tbl[6] = '{1, 0, 0,  32'b00000, 0};
      tbl[7] = '{1, 3, 30, 32'b11100, 0};

      // Reset state
      tick(); tick();
      chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
      chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
      chk("rst_out_bit", 64'(ia.out_bit), 64'd0);
      chk("rst_out_last", 64'(ia.out_last), 64'd0);
      chk("rst_ovf", 64'(ovf_b), 64'd0);
      chk("rst_frame_cnt", 64'(fc_a), 64'd0);
      rst_n = 1'b1;
      tick();

      // Table-driven frames
      foreach (tbl[i]) begin
         s = tbl[i].sel;
         accept(s, tbl[i].cnt);
         chk("first_bit_latency", 64'(g_vld(s)), 64'd1);
         chk("ovf_pulse", 64'(g_ovf(s)), 64'(tbl[i].exp_ovf));
         set_ord(s, 1'b0);
         tick();
         chk("ovf_one_cycle", 64'(g_ovf(s)), 64'd0);
         run_frame(s, flen(s), tbl[i].stall, bits, len, cyc);
         chk("tbl_bits", 64'(bits), 64'(tbl[i].exp_bits));
         chk("tbl_len", 64'(len), 64'(flen(s)));
         if (tbl[i].stall == 0) chk("tbl_cycles", 64'(cyc), 64'(flen(s)));
         frame_done(s);
      end

      // Back-to-back: in_valid held through a SEND frame is ignored, then taken after one bubble.
      accept(0, 3);
      set_in(0, 1'b1, 0);
      run_frame(0, FLA, 0, bits, len, cyc);
      chk("b2b_first_bits", 64'(bits), 64'b111);
      frame_done(0);
      tick();
      set_in(0, 1'b0, 0);
      chk("b2b_second_valid", 64'(ia.out_valid), 64'd1);
      run_frame(0, FLA, 0, bits, len, cyc);
      chk("b2b_second_bits", 64'(bits), 64'b000);
      frame_done(0);

      // Stall on beat 2 of a count=1 frame
      accept(0, 1);
      set_ord(0, 1'b1);
      tick();
      set_ord(0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("stall_valid", 64'(ia.out_valid), 64'd1);
         chk("stall_bit", 64'(ia.out_bit), 64'd0);
         chk("stall_last", 64'(ia.out_last), 64'd0);
         tick();
      end
      set_ord(0, 1'b1);
      chk("stall_beat2_bit", 64'(ia.out_bit), 64'd0);
      tick();
      chk("stall_beat3_last", 64'(ia.out_last), 64'd1);
      chk("stall_beat3_bit", 64'(ia.out_bit), 64'd0);
      tick();
      set_ord(0, 1'b0);
      frame_done(0);

      // Reset mid-frame
      accept(0, 3);
      set_ord(0, 1'b1);
      tick();
      chk("pre_rst_bit", 64'(ia.out_bit), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(ia.in_ready), 64'd1);
      chk("mid_rst_out_valid", 64'(ia.out_valid), 64'd0);
      chk("mid_rst_out_bit", 64'(ia.out_bit), 64'd0);
      chk("mid_rst_out_last", 64'(ia.out_last), 64'd0);
      chk("mid_rst_frame_cnt", 64'(fc_a), 64'd0);
      fcm[0] = 0; fcm[1] = 0;
      set_ord(0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("no_resume", 64'(ia.out_valid), 64'd0);
      accept(0, 2);
      run_frame(0, FLA, 0, bits, len, cyc);
      chk("post_rst_bits", 64'(bits), 64'b110);
      frame_done(0);

      // Random scoreboard
      for (int it = 0; it < 60; it++) begin
         s = int'($urandom_range(1));
         c = int'($urandom_range(s ? 7 : 3));
         repeat ($urandom_range(2)) tick();
         accept(s, c);
         chk("rnd_ovf", 64'(g_ovf(s)), 64'(c > flen(s)));
         run_frame(s, flen(s), 30, bits, len, cyc);
         chk("rnd_popcount", 64'($countones(bits)), 64'((c > flen(s)) ? flen(s) : c));
         chk("rnd_bits", 64'(bits), 64'(thermo(c, flen(s))));
         frame_done(s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
